regfile_scoreboard: RTL

- Architectural integer register file on the consuming side of the writeback interface.
- Accepts one retiring write per cycle (regwrite / wa / result) from the writeback stage and serves two combinational read ports to decode.
- Bypasses same-cycle writeback data to the read ports.
- Keeps a per-register pending-write scoreboard (issue increments, retire or squash decrements) so decode can stall on registers whose producer is still in flight.

---
 rtl/regfile_scoreboard.sv | 63 ++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with writeback bypass and per-register pending-write counters
module regfile_scoreboard #(
    parameter int NREG  = 32,
    parameter int XLEN  = 64,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            issue_valid,
    input  logic            issue_regwrite,
    input  logic [4:0]      issue_wa,
    output logic            issue_ready,
    input  logic            wb_regwrite,
    input  logic [4:0]      wb_wa,
    input  logic [XLEN-1:0] wb_result,
    input  logic            squash_valid,
    input  logic [4:0]      squash_wa,
    output logic            err
);
    localparam logic [CNT_W-1:0] CMAX = '1;
    logic [XLEN-1:0]  regs_q [NREG];
    logic [CNT_W-1:0] cnt_q  [NREG];
    logic [CNT_W-1:0] cnt_d  [NREG];
    logic [NREG-1:0]  inc, dwb, dsq, uf;
    logic             err_q, err_d, forced;
    for (genvar r = 0; r < NREG; r++) begin : g_cnt
        logic [CNT_W+1:0] sum;
        assign inc[r] = (r != 0) && issue_valid && issue_ready && issue_regwrite && issue_wa == 5'(r);
        assign dwb[r] = (r != 0) && wb_regwrite && wb_wa == 5'(r);
        assign dsq[r] = (r != 0) && squash_valid && squash_wa == 5'(r);
        assign sum = {2'b00, cnt_q[r]} + (CNT_W+2)'(inc[r]) - (CNT_W+2)'(dwb[r]) - (CNT_W+2)'(dsq[r]);
        assign uf[r] = sum[CNT_W+1];
        assign cnt_d[r] = uf[r] ? '0 : sum[CNT_W-1:0];
    end
    // A retire or squash of the same register this cycle frees a slot for a saturated counter
    assign issue_ready = !(issue_regwrite && issue_wa != 0 && cnt_q[issue_wa] == CMAX && !dwb[issue_wa] && !dsq[issue_wa]);
    assign forced = issue_valid && !issue_ready;
    assign err_d = err_q | (|uf) | forced;
    assign err = err_q;
    assign rd1 = ra1 == 0 ? '0 : (wb_regwrite && wb_wa == ra1) ? wb_result : regs_q[ra1];
    assign rd2 = ra2 == 0 ? '0 : (wb_regwrite && wb_wa == ra2) ? wb_result : regs_q[ra2];
    assign busy1 = ra1 != 0 && cnt_q[ra1] != CNT_W'(dwb[ra1]);
    assign busy2 = ra2 != 0 && cnt_q[ra2] != CNT_W'(dwb[ra2]);
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (wb_regwrite && wb_wa != 0) regs_q[wb_wa] <= wb_result;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
endmodule
